proc_ctrl_seq: RTL

- Multi-cycle sequencer for the 8-bit processor.
- Owns PC, IR, operand/pointer registers and Z/O flags.
- Drives the single shared memory port, the register-file selects/write-enable and the ALU op.
- Sits between the memory model and the 4x8 register file/ALU datapath. Executes the 16-opcode ISA; instruction byte is {op[3:0], rd[1:0], rs[1:0]}.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/proc_ctrl_seq_if.sv | 14 +
 rtl/proc_ctrl_memif.sv | 33 +++
 rtl/proc_ctrl_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, register, state and write-source encodings for proc_ctrl_seq
package proc_pkg;

    // Instruction byte is {op[3:0], rd[1:0], rs[1:0]}
    typedef enum logic [3:0] {
        OP_IADD   = 4'd0,
        OP_ISUB   = 4'd1,
        OP_IAND   = 4'd2,
        OP_INOT   = 4'd3,
        OP_IOR    = 4'd4,
        OP_IMUL   = 4'd5,
        OP_NOP    = 4'd6,
        OP_REGD   = 4'd7,
        OP_REGID  = 4'd8,
        OP_READ   = 4'd9,
        OP_READI  = 4'd10,
        OP_WRITE  = 4'd11,
        OP_WRITEI = 4'd12,
        OP_BUC    = 4'd13,
        OP_BIZ    = 4'd14,
        OP_BIO    = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} reg_e;

    typedef enum logic [1:0] {
        WSRC_ALU = 2'd0,
        WSRC_MEM = 2'd1,
        WSRC_RS  = 2'd2
    } wsrc_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_FETCH_OP, ST_FETCH_PTR,
        ST_MEM_RD, ST_MEM_WR, ST_EXEC, ST_ERR
    } state_e;

    // State that follows the instruction fetch, decoded from the fetched opcode
    function automatic state_e fetch_next(input logic [3:0] op);
        if (op <= 4'd7)       return ST_EXEC;
        else if (op == 4'd8)  return ST_MEM_RD;
        else                  return ST_FETCH_OP;
    endfunction

endpackage

// File: rtl/proc_ctrl_seq_if.sv
// rtl/proc_ctrl_seq_if.sv - single shared memory port between sequencer (master) and memory (slave)
interface proc_ctrl_seq_if;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (output mem_addr, mem_req, mem_we, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_addr, mem_req, mem_we, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/proc_ctrl_memif.sv
// rtl/proc_ctrl_memif.sv - memory handshake qualifier, wait-state counter and ack timeout detect
// Ports: clk, rst (async active-low), req_i (sequencer is in a request state),
//        ack_i (memory ack), ack_fire_o (transfer completes this edge), timeout_o (give up this edge)
module proc_ctrl_memif #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic ack_fire_o,
    output logic timeout_o
);
    logic [7:0] wait_q, wait_d;

    // An ack without a request is ignored
    assign ack_fire_o = req_i & ack_i;
    // wait_q counts completed unacked cycles; this is the ACK_TIMEOUT-th one
    assign timeout_o  = req_i & ~ack_i & (wait_q == 8'(ACK_TIMEOUT - 1));

    // Any cycle without a request (including the cycle before a request state
    // is entered) or with an ack clears the count
    always_comb begin
        wait_d = '0;
        if (req_i && !ack_i)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_q <= '0;
        else      wait_q <= wait_d;
    end
endmodule

// File: rtl/proc_ctrl_seq.sv
// rtl/proc_ctrl_seq.sv - multi-cycle sequencer for the 8-bit processor (PC, IR, OPR, PTR, Z/O)
// Ports: clk, rst (async active-low), run; mem (memory port, master);
//        rf_rd_sel/rf_rs_sel/rf_rd_data/rf_rs_data/rf_we/rf_wsrc (register file);
//        alu_op/alu_en/alu_zero/alu_ovf (ALU); pc; bus_err (sticky ack timeout)
module proc_ctrl_seq
    import proc_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'd0,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    proc_ctrl_seq_if.master        mem,
    output logic [1:0]             rf_rd_sel,
    output logic [1:0]             rf_rs_sel,
    input  logic [7:0]             rf_rd_data,
    input  logic [7:0]             rf_rs_data,
    output logic                   rf_we,
    output logic [1:0]             rf_wsrc,
    output logic [2:0]             alu_op,
    output logic                   alu_en,
    input  logic                   alu_zero,
    input  logic                   alu_ovf,
    output logic [7:0]             pc,
    output logic                   bus_err
);
    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d, ir_q, ir_d, opr_q, opr_d, ptr_q, ptr_d;
    logic       z_q, z_d, o_q, o_d;

    logic       req, we, ack_fire, timeout;
    logic [7:0] addr, wdata;
    opcode_e    op;
    state_e     end_state;

    assign op        = opcode_e'(ir_q[7:4]);
    assign end_state = run ? ST_FETCH : ST_IDLE;

    proc_ctrl_memif #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_memif (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .ack_i      (mem.mem_ack),
        .ack_fire_o (ack_fire),
        .timeout_o  (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            opr_q   <= '0;
            ptr_q   <= '0;
            z_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            ptr_q   <= ptr_d;
            z_q     <= z_d;
            o_q     <= o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        ptr_d   = ptr_q;
        z_d     = z_q;
        o_d     = o_q;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        rf_we   = 1'b0;
        rf_wsrc = WSRC_ALU;
        alu_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                req  = 1'b1;
                addr = pc_q;
                if (ack_fire) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = fetch_next(mem.mem_rdata[7:4]);
                end
            end
            ST_FETCH_OP: begin
                req  = 1'b1;
                addr = pc_q;
                if (ack_fire) begin
                    opr_d = mem.mem_rdata;
                    pc_d  = pc_q + 8'd1;
                    // Branch target comes straight off the bus; flags are the ones held now
                    case (op)
                        OP_READ:             state_d = ST_MEM_RD;
                        OP_READI, OP_WRITEI: state_d = ST_FETCH_PTR;
                        OP_WRITE:            state_d = ST_MEM_WR;
                        OP_BUC: begin
                            pc_d    = mem.mem_rdata;
                            state_d = end_state;
                        end
                        OP_BIZ: begin
                            if (z_q) pc_d = mem.mem_rdata;
                            state_d = end_state;
                        end
                        OP_BIO: begin
                            if (o_q) pc_d = mem.mem_rdata;
                            state_d = end_state;
                        end
                        default:             state_d = end_state;
                    endcase
                end
            end
            ST_FETCH_PTR: begin
                req  = 1'b1;
                addr = opr_q;
                if (ack_fire) begin
                    ptr_d   = mem.mem_rdata;
                    state_d = (op == OP_READI) ? ST_MEM_RD : ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                req     = 1'b1;
                addr    = (op == OP_REGID) ? rf_rs_data :
                          (op == OP_READ)  ? opr_q : ptr_q;
                rf_wsrc = WSRC_MEM;
                rf_we   = ack_fire;
                if (ack_fire) state_d = end_state;
            end
            ST_MEM_WR: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = (op == OP_WRITE) ? opr_q : ptr_q;
                wdata = rf_rd_data;
                if (ack_fire) state_d = end_state;
            end
            ST_EXEC: begin
                state_d = end_state;
                if (op <= OP_IMUL) begin
                    alu_en = 1'b1;
                    rf_we  = 1'b1;
                    z_d    = alu_zero;
                    o_d    = alu_ovf;
                end else if (op == OP_REGD) begin
                    rf_wsrc = WSRC_RS;
                    rf_we   = 1'b1;
                end
            end
            ST_ERR: state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        if (timeout) state_d = ST_ERR;
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
    assign rf_rd_sel     = ir_q[3:2];
    assign rf_rs_sel     = ir_q[1:0];
    assign alu_op        = ir_q[6:4];
    assign pc            = pc_q;
    assign bus_err       = (state_q == ST_ERR);
endmodule
